// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder; MDIO_PREAMBLE_SUPPRESS_EN enables short-preamble acceptance.
// Outputs change 3 i_clk after a rising MDC pin edge; the register port is fire-and-forget (no backpressure).
module mdio_responder #(
  parameter logic [4:0] PHYADDR       = 5'h01,
  parameter int         PREAMBLE_BITS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mdclk,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        o_mdwe,
  output logic [4:0]  o_reg_addr,
  output logic        o_reg_rd,
  input  logic [15:0] i_reg_rdata,
  output logic        o_reg_wr,
  output logic [15:0] o_reg_wdata,
  output logic        o_busy
);
  typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA} state_t;
  localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_BITS);

  state_t      state, state_nx;
  logic [2:0]  mdc_sync;
  logic [1:0]  mdio_sync;
  logic        mdc_rise, bit_in, pre_ok, go_idle;
  logic [4:0]  cnt, cnt_nx;
  logic [5:0]  pre_cnt, pre_nx;
  logic [15:0] shreg, shreg_nx;
  logic        is_rd, is_rd_nx, rd_d, wr_pend, wr_pend_nx;
  logic        mdio_nx, mdwe_nx, reg_rd_nx;
  logic [4:0]  addr_nx;
  logic [15:0] wdata_nx;

  assign mdc_rise = mdc_sync[1] & ~mdc_sync[2];
  assign bit_in   = mdio_sync[1];
  assign o_busy   = (state != IDLE);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign pre_ok = (pre_cnt != 6'd0);
`else
  assign pre_ok = (pre_cnt == PRE_MAX);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mdc_sync    <= '0;
      mdio_sync   <= '1;
      state       <= IDLE;
      cnt         <= '0;
      pre_cnt     <= '0;
      shreg       <= '0;
      is_rd       <= 1'b0;
      rd_d        <= 1'b0;
      wr_pend     <= 1'b0;
      o_mdio      <= 1'b1;
      o_mdwe      <= 1'b0;
      o_reg_addr  <= '0;
      o_reg_rd    <= 1'b0;
      o_reg_wr    <= 1'b0;
      o_reg_wdata <= '0;
    end else begin
      mdc_sync    <= {mdc_sync[1:0], i_mdclk};
      mdio_sync   <= {mdio_sync[0], i_mdio};
      state       <= state_nx;
      cnt         <= cnt_nx;
      pre_cnt     <= pre_nx;
      shreg       <= shreg_nx;
      is_rd       <= is_rd_nx;
      rd_d        <= o_reg_rd;
      wr_pend     <= wr_pend_nx;
      o_mdio      <= mdio_nx;
      o_mdwe      <= mdwe_nx;
      o_reg_addr  <= addr_nx;
      o_reg_rd    <= reg_rd_nx;
      o_reg_wr    <= wr_pend;
      o_reg_wdata <= wdata_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pre_nx     = pre_cnt;
    shreg_nx   = shreg;
    is_rd_nx   = is_rd;
    mdio_nx    = o_mdio;
    mdwe_nx    = o_mdwe;
    addr_nx    = o_reg_addr;
    wdata_nx   = o_reg_wdata;
    reg_rd_nx  = 1'b0;
    wr_pend_nx = 1'b0;
    go_idle    = 1'b0;
    // read data arrives one cycle after the strobe, long before the TA[0] edge
    if (rd_d) shreg_nx = i_reg_rdata;
    if (mdc_rise) begin
      case (state)
        IDLE: begin
          if (bit_in) begin
            if (pre_cnt != PRE_MAX) pre_nx = pre_cnt + 6'd1;
          end else if (pre_ok) begin
            state_nx = ST;
          end else begin
            pre_nx = '0;
          end
        end
        ST: begin
          cnt_nx = '0;
          if (bit_in) state_nx = OP;
          else        go_idle  = 1'b1;
        end
        OP: begin
          shreg_nx = {shreg[14:0], bit_in};
          cnt_nx   = cnt + 5'd1;
          if (cnt == 5'd1) begin
            cnt_nx   = '0;
            state_nx = PHYAD;
            case ({shreg[0], bit_in})
              2'b10:   is_rd_nx = 1'b1;
              2'b01:   is_rd_nx = 1'b0;
              default: go_idle  = 1'b1;
            endcase
          end
        end
        PHYAD: begin
          shreg_nx = {shreg[14:0], bit_in};
          cnt_nx   = cnt + 5'd1;
          if (cnt == 5'd4) begin
            cnt_nx   = '0;
            state_nx = REGAD;
            if ({shreg[3:0], bit_in} != PHYADDR) go_idle = 1'b1;
          end
        end
        REGAD: begin
          shreg_nx = {shreg[14:0], bit_in};
          cnt_nx   = cnt + 5'd1;
          if (cnt == 5'd4) begin
            cnt_nx    = '0;
            state_nx  = TA;
            addr_nx   = {shreg[3:0], bit_in};
            reg_rd_nx = is_rd;
          end
        end
        TA: begin
          if (cnt == 5'd0) begin
            cnt_nx = 5'd1;
            if (!is_rd && !bit_in) go_idle = 1'b1;
          end else if (is_rd) begin
            cnt_nx   = '0;
            mdwe_nx  = 1'b1;
            mdio_nx  = 1'b0;
            state_nx = RDATA;
          end else begin
            cnt_nx   = '0;
            state_nx = WDATA;
            if (bit_in) go_idle = 1'b1;
          end
        end
        RDATA: begin
          if (cnt == 5'd16) begin
            mdwe_nx = 1'b0;
            mdio_nx = 1'b1;
            go_idle = 1'b1;
          end else begin
            mdio_nx  = shreg[15];
            shreg_nx = {shreg[14:0], 1'b0};
            cnt_nx   = cnt + 5'd1;
          end
        end
        WDATA: begin
          shreg_nx = {shreg[14:0], bit_in};
          cnt_nx   = cnt + 5'd1;
          if (cnt == 5'd15) begin
            wdata_nx   = {shreg[14:0], bit_in};
            wr_pend_nx = 1'b1;
            go_idle    = 1'b1;
          end
        end
        default: go_idle = 1'b1;
      endcase
    end
    if (go_idle) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      pre_nx   = '0;
    end
  end
endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: bit-level MDIO master, register-file peripheral, frame-level reference model.
module tb_mdio_responder;
  localparam int HALF = 8;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam bit SUPPRESS = 1'b1;
`else
  localparam bit SUPPRESS = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        mdc = 1'b0;
  logic        m_drv = 1'b1;
  logic        m_oe = 1'b0;
  logic        mdio_line;
  logic        o_mdio, o_mdwe, o_reg_rd, o_reg_wr, o_busy;
  logic [4:0]  o_reg_addr;
  logic [15:0] i_reg_rdata, o_reg_wdata;

  logic [15:0] mem [32];
  logic [15:0] init_mem [32];
  logic [15:0] model_mem [32];
  logic        mem_load = 1'b0;
  logic        busy_log [32];
  int          n_checks = 0, n_errors = 0;
  int          rd_cnt = 0, wr_cnt = 0, we_cycles = 0;
  logic [4:0]  rd_addr_seen = '0, wr_addr_seen = '0;
  logic [15:0] wdata_seen = '0;

  always #5 i_clk = ~i_clk;
  assign mdio_line = o_mdwe ? o_mdio : (m_oe ? m_drv : 1'b1);

  mdio_responder #(.PHYADDR(5'h01), .PREAMBLE_BITS(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mdclk(mdc), .i_mdio(mdio_line),
    .o_mdio(o_mdio), .o_mdwe(o_mdwe), .o_reg_addr(o_reg_addr), .o_reg_rd(o_reg_rd),
    .i_reg_rdata(i_reg_rdata), .o_reg_wr(o_reg_wr), .o_reg_wdata(o_reg_wdata), .o_busy(o_busy)
  );

  // register file behind the port: data valid only in the cycle after the strobe
  always @(posedge i_clk) begin
    i_reg_rdata <= o_reg_rd ? mem[o_reg_addr] : 16'($urandom);
    if (mem_load) for (int k = 0; k < 32; k++) mem[k] <= init_mem[k];
    else if (o_reg_wr) mem[o_reg_addr] <= o_reg_wdata;
  end

  always @(negedge i_clk) begin
    if (o_mdwe) we_cycles++;
    if (o_reg_rd) begin rd_cnt++; rd_addr_seen = o_reg_addr; end
    if (o_reg_wr) begin wr_cnt++; wr_addr_seen = o_reg_addr; wdata_seen = o_reg_wdata; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_answers(input int pre_len, input logic [1:0] op,
                                       input logic [4:0] phy, input logic [1:0] ta);
    int need;
    need = SUPPRESS ? 1 : 32;
    if (pre_len < need || phy != 5'h01) return 1'b0;
    if (op == 2'b10) return 1'b1;
    return (op == 2'b01) && (ta == 2'b10);
  endfunction

  // one MDC period; entered and left just after a posedge with MDC low
  task automatic cycle(input logic drv, input logic oe, input bit do_rst,
                       output logic line_s, output logic we_s, output logic busy_s);
    m_drv = drv;
    m_oe  = oe;
    repeat (HALF) @(posedge i_clk);
    #1 mdc = 1'b1;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk) busy_s = o_busy;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    line_s = mdio_line;
    we_s   = o_mdwe;
    if (do_rst) begin
      i_rst_n = 1'b0;
      #1;
      check("rst_mid_mdwe", 32'(o_mdwe), 32'd0);
      check("rst_mid_busy", 32'(o_busy), 32'd0);
      check("rst_mid_mdio", 32'(o_mdio), 32'd1);
    end
    @(posedge i_clk);
    #1 mdc = 1'b0;
    i_rst_n = 1'b1;
  endtask

  task automatic frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                       input int rst_at, output logic [15:0] rd_word,
                       output logic ta1_we, output logic ta0_we, output logic ta0_line);
    logic [31:0] hdr;
    logic l, w, b, rel, rst_now;
    hdr = {2'b01, op, phy, ra, ta, wd};
    rd_word = '0; ta1_we = 1'b0; ta0_we = 1'b0; ta0_line = 1'b1;
    for (int i = 0; i < pre_len; i++) cycle(1'b1, 1'b1, 1'b0, l, w, b);
    for (int i = 0; i < 32; i++) begin
      rel     = (op == 2'b10) && (i >= 14);
      rst_now = (rst_at >= 0) && (i == 16 + rst_at);
      cycle(hdr[31-i], !rel, rst_now, l, w, b);
      busy_log[i] = b;
      if (i == 14) ta1_we = w;
      if (i == 15) begin ta0_we = w; ta0_line = l; end
      if (i >= 16) rd_word[31-i] = l;
      if (rst_now) return;
    end
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, l, w, b);
  endtask

  task automatic run_and_check(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                               input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd);
    bit exp;
    int rd0, wr0, we0;
    logic [15:0] word;
    logic t1w, t0w, t0l;
    exp = model_answers(pre_len, op, phy, ta);
    rd0 = rd_cnt; wr0 = wr_cnt; we0 = we_cycles;
    frame(pre_len, op, phy, ra, ta, wd, -1, word, t1w, t0w, t0l);
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    if (op == 2'b10) begin
      check("rd_strobes", 32'(rd_cnt - rd0), 32'(exp));
      check("rd_no_wr", 32'(wr_cnt - wr0), 32'd0);
      check("rd_mdwe_cycles", 32'(we_cycles - we0), exp ? 32'd272 : 32'd0);
      if (exp) begin
        check("rd_addr", 32'(rd_addr_seen), 32'(ra));
        check("ta1_tristate", 32'(t1w), 32'd0);
        check("ta0_drive_zero", 32'({t0w, t0l}), 32'b10);
        check("rd_data", 32'(word), 32'(model_mem[ra]));
      end
    end else begin
      check("wr_strobes", 32'(wr_cnt - wr0), 32'(exp));
      check("wr_no_rd", 32'(rd_cnt - rd0), 32'd0);
      check("wr_mdwe_cycles", 32'(we_cycles - we0), 32'd0);
      if (exp) begin
        check("wr_addr", 32'(wr_addr_seen), 32'(ra));
        check("wr_data", 32'(wdata_seen), 32'(wd));
        model_mem[ra] = wd;
      end
    end
    check("end_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [15:0] word;
    logic t1w, t0w, t0l;
    logic [4:0] ra;
    logic [15:0] wd;
    int kind, pre, rd0, wr0;

    for (int k = 0; k < 32; k++) begin
      init_mem[k]  = 16'($urandom);
      model_mem[k] = init_mem[k];
    end
    init_mem[2] = 16'h2000;
    model_mem[2] = 16'h2000;
    mem_load = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 mem_load = 1'b0;
    @(negedge i_clk);
    check("rst_mdio", 32'(o_mdio), 32'd1);
    check("rst_mdwe", 32'(o_mdwe), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_reg_rd", 32'(o_reg_rd), 32'd0);
    check("rst_reg_wr", 32'(o_reg_wr), 32'd0);
    check("rst_reg_addr", 32'(o_reg_addr), 32'd0);
    check("rst_reg_wdata", 32'(o_reg_wdata), 32'd0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // directed frames
    run_and_check(32, 2'b10, 5'h01, 5'h02, 2'b10, 16'h0);
    run_and_check(32, 2'b01, 5'h01, 5'h00, 2'b10, 16'h8000);
    run_and_check(32, 2'b10, 5'h03, 5'h1f, 2'b10, 16'h0);
    check("badphy_busy_before", 32'(busy_log[7]), 32'd1);
    check("badphy_busy_after", 32'(busy_log[8]), 32'd0);
    run_and_check(32, 2'b01, 5'h01, 5'h05, 2'b11, 16'hffff);
    run_and_check(32, 2'b10, 5'h01, 5'h00, 2'b10, 16'h0);
    run_and_check(4, 2'b10, 5'h01, 5'h02, 2'b10, 16'h0);
    run_and_check(32, 2'b10, 5'h01, 5'h02, 2'b10, 16'h0);

    // reset while the responder is driving read data
    rd0 = rd_cnt; wr0 = wr_cnt;
    frame(32, 2'b10, 5'h01, 5'h07, 2'b10, 16'h0, 5, word, t1w, t0w, t0l);
    check("abort_rd_once", 32'(rd_cnt - rd0), 32'd1);
    check("abort_no_wr", 32'(wr_cnt - wr0), 32'd0);
    run_and_check(32, 2'b10, 5'h01, 5'h07, 2'b10, 16'h0);

    // randomized traffic
    for (int i = 0; i < 14; i++) begin
      kind = $urandom_range(0, 4);
      pre  = $urandom_range(32, 40);
      ra   = 5'($urandom);
      wd   = 16'($urandom);
      case (kind)
        0, 1:    run_and_check(pre, 2'b10, 5'h01, ra, 2'b10, wd);
        2, 3:    run_and_check(pre, 2'b01, 5'h01, ra, 2'b10, wd);
        default: run_and_check(pre, 2'b10, 5'($urandom_range(2, 31)), 5'h1f, 2'b10, wd);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
